// File: rtl/riscv_mon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : riscv_mon_pkg                                                   |
// | Brief    : Shared types and constants for the store monitor.               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package riscv_mon_pkg;

    localparam int unsigned MON_XLEN        = 32;
    localparam int unsigned TOHOST_PASS_VAL = 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } mon_state_t;

    typedef struct packed {
        logic [MON_XLEN-1:0] addr;
        logic [MON_XLEN-1:0] data;
    } trace_entry_t;

endpackage
`default_nettype wire

// File: rtl/mon_trace_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mon_trace_fifo                                                  |
// | Brief    : Show-ahead FIFO with sticky overflow flag for the store trace.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mon_trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int unsigned          c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]        c_CNT_FULL = DEPTH[c_AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             r_ovf;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_FULL);
    assign w_pop   = pop && !w_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_push  = push && (!w_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (c_AW+1)'(1);
            else if (w_pop && !w_push) r_count <= r_count - (c_AW+1)'(1);
            if (push && !w_push) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign valid   = !w_empty;
    assign count   = r_count;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: rtl/riscv_store_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : riscv_store_monitor                                             |
// | Brief    : Store trace capture, TOHOST pass/fail decode and watchdog.      |
// |            Define RISCV_STORE_MON_PRINT_EN for simulation store printing.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module riscv_store_monitor
    import riscv_mon_pkg::*;
#(
    parameter int unsigned     XLEN           = 32,
    parameter int unsigned     TRACE_DEPTH    = 16,
    parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'(32'h100),
    parameter int unsigned     TIMEOUT_CYCLES = 10000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           mem_write,
    input  logic [XLEN-1:0]                data_addr_m,
    input  logic [XLEN-1:0]                write_data_m,
    input  logic                           trace_rd_en,
    output logic                           trace_valid,
    output logic [XLEN-1:0]                trace_addr,
    output logic [XLEN-1:0]                trace_data,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    output logic                           trace_ovf,
    output logic                           done,
    output logic                           pass,
    output logic [XLEN-1:0]                fail_code,
    output logic [31:0]                    cycle_count
);

    localparam logic [31:0] c_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    mon_state_t      r_state;
    mon_state_t      w_state_next;
    logic            r_done;
    logic            r_pass;
    logic [XLEN-1:0] r_fail_code;
    logic [31:0]     r_cycle_count;

    logic            w_capture;
    logic            w_tohost;
    logic            w_timeout_hit;
    logic [2*XLEN-1:0] w_head;

    assign w_capture     = mem_write && (r_state == RUN);
    assign w_tohost      = w_capture && (data_addr_m == TOHOST_ADDR);
    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_cycle_count == c_TIMEOUT_LAST);

    // TOHOST decode wins over a watchdog expiry in the same cycle.
    always_comb begin
        w_state_next = r_state;
        if (r_state == RUN) begin
            if (w_tohost) begin
                w_state_next = (write_data_m == XLEN'(TOHOST_PASS_VAL)) ? PASS : FAIL;
            end else if (w_timeout_hit) begin
                w_state_next = TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail_code   <= '0;
            r_cycle_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (w_state_next != RUN);
            r_pass  <= (w_state_next == PASS);
            if (r_state == RUN && w_state_next == FAIL) r_fail_code <= write_data_m >> 1;
            if (r_state == RUN && r_cycle_count != '1)  r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    mon_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (2*XLEN)
    ) u_trace_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_capture),
        .wr_data ({data_addr_m, write_data_m}),
        .pop     (trace_rd_en),
        .rd_data (w_head),
        .valid   (trace_valid),
        .count   (trace_count),
        .ovf     (trace_ovf)
    );

    assign trace_addr  = w_head[2*XLEN-1:XLEN];
    assign trace_data  = w_head[XLEN-1:0];
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_code   = r_fail_code;
    assign cycle_count = r_cycle_count;

`ifdef RISCV_STORE_MON_PRINT_EN
`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && w_capture)
            $display("%0t %h %h", $time, data_addr_m, write_data_m);
        if (!rst && r_state == RUN && w_state_next != RUN)
            $display("%0t store monitor terminal state: %s", $time,
                     (w_state_next == PASS) ? "pass" :
                     (w_state_next == FAIL) ? "fail" : "timeout");
    end
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_store_monitor.sv
`default_nettype none
// Bench for riscv_store_monitor: directed scenarios plus randomized traffic
// checked against a queue-based reference model (depth 4, watchdog 50).
module tb_riscv_store_monitor;

    localparam int          DEPTH  = 4;
    localparam int          TMO    = 50;
    localparam logic [31:0] TOHOST = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_write = 1'b0;
    logic        trace_rd_en = 1'b0;
    logic [31:0] data_addr_m = '0;
    logic [31:0] write_data_m = '0;
    logic        trace_valid;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic [2:0]  trace_count;
    logic        trace_ovf;
    logic        done;
    logic        pass;
    logic [31:0] fail_code;
    logic [31:0] cycle_count;

    always #5 clk = ~clk;

    riscv_store_monitor #(
        .XLEN           (32),
        .TRACE_DEPTH    (DEPTH),
        .TOHOST_ADDR    (TOHOST),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_write    (mem_write),
        .data_addr_m  (data_addr_m),
        .write_data_m (write_data_m),
        .trace_rd_en  (trace_rd_en),
        .trace_valid  (trace_valid),
        .trace_addr   (trace_addr),
        .trace_data   (trace_data),
        .trace_count  (trace_count),
        .trace_ovf    (trace_ovf),
        .done         (done),
        .pass         (pass),
        .fail_code    (fail_code),
        .cycle_count  (cycle_count)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: trace as a queue, test outcome as 0 run/1 pass/2 fail/3 timeout.
    logic [63:0] m_q[$];
    int          m_state;
    logic        m_ovf;
    logic [31:0] m_fail;
    logic [31:0] m_cyc;

    function automatic void model_reset();
        m_q.delete();
        m_state = 0;
        m_ovf   = 1'b0;
        m_fail  = '0;
        m_cyc   = '0;
    endfunction

    function automatic void model_step(input logic we, input logic [31:0] a, input logic [31:0] d,
                                       input logic rd);
        bit do_pop, do_push, was_full;
        do_pop   = rd && (m_q.size() > 0);
        do_push  = we && (m_state == 0);
        was_full = (m_q.size() == DEPTH);
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
            if (!was_full || do_pop) m_q.push_back({a, d});
            else m_ovf = 1'b1;
        end
        if (m_state == 0) begin
            if (do_push && a == TOHOST) begin
                if (d == 32'd1) m_state = 1;
                else begin
                    m_state = 2;
                    m_fail  = d >> 1;
                end
            end else if (m_cyc == TMO - 1) begin
                m_state = 3;
            end
            m_cyc = m_cyc + 1;
        end
    endfunction

    task automatic tick(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rd);
        mem_write    = we;
        data_addr_m  = a;
        write_data_m = d;
        trace_rd_en  = rd;
        @(posedge clk);
        model_step(we, a, d, rd);
        #1;
        mem_write   = 1'b0;
        trace_rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (trace_valid !== 1'b0 || trace_count !== 3'd0 || trace_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_fifo valid=%b count=%0d ovf=%b required 0/0/0", trace_valid, trace_count, trace_ovf);
        end
        checks++;
        if (trace_addr !== 32'd0 || trace_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_head addr=%h data=%h required 0/0", trace_addr, trace_data);
        end
        checks++;
        if (done !== 1'b0 || pass !== 1'b0 || fail_code !== 32'd0 || cycle_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_status done=%b pass=%b fail_code=%h cyc=%0d required all 0", done, pass, fail_code, cycle_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_capture_and_drain();
        logic [31:0] heads_a [2];
        logic [31:0] heads_d [2];
        heads_a[0] = 32'h14; heads_d[0] = 32'hB;
        heads_a[1] = 32'h18; heads_d[1] = 32'hC;
        do_reset();
        tick(1'b1, 32'h10, 32'hA, 1'b0);
        tick(1'b1, 32'h14, 32'hB, 1'b0);
        tick(1'b1, 32'h18, 32'hC, 1'b0);
        checks++;
        if (trace_count !== 3'd3 || trace_addr !== 32'h10 || trace_data !== 32'hA || trace_valid !== 1'b1) begin
            failures++;
            $display("FAIL capture3 count=%0d addr=%h data=%h required 3/10/a", trace_count, trace_addr, trace_data);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 32'h0, 32'h0, 1'b1);
            checks++;
            if (trace_valid !== 1'b1 || trace_addr !== heads_a[i] || trace_data !== heads_d[i]) begin
                failures++;
                $display("FAIL drain_head%0d addr=%h data=%h required %h/%h", i, trace_addr, trace_data, heads_a[i], heads_d[i]);
            end
        end
        tick(1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (trace_valid !== 1'b0 || trace_count !== 3'd0 || cycle_count !== 32'd6) begin
            failures++;
            $display("FAIL drain_empty valid=%b count=%0d cyc=%0d required 0/0/6", trace_valid, trace_count, cycle_count);
        end
    endtask

    task automatic test_pass();
        do_reset();
        tick(1'b1, 32'h30, 32'h5, 1'b0);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL pass_predone done=%b required 0", done);
        end
        tick(1'b1, TOHOST, 32'd1, 1'b0);
        checks++;
        if (pass !== 1'b1 || done !== 1'b1 || fail_code !== 32'd0) begin
            failures++;
            $display("FAIL pass_status pass=%b done=%b fail_code=%h required 1/1/0", pass, done, fail_code);
        end
        tick(1'b1, 32'h40, 32'h9, 1'b0);
        checks++;
        if (trace_count !== 3'd2 || done !== 1'b1 || cycle_count !== 32'd2) begin
            failures++;
            $display("FAIL pass_frozen count=%0d done=%b cyc=%0d required 2/1/2", trace_count, done, cycle_count);
        end
    endtask

    task automatic test_fail();
        do_reset();
        tick(1'b1, TOHOST, 32'd7, 1'b0);
        checks++;
        if (pass !== 1'b0 || done !== 1'b1 || fail_code !== 32'd3) begin
            failures++;
            $display("FAIL fail_status pass=%b done=%b fail_code=%h required 0/1/3", pass, done, fail_code);
        end
        checks++;
        if (trace_addr !== TOHOST || trace_data !== 32'd7 || trace_count !== 3'd1) begin
            failures++;
            $display("FAIL fail_captured addr=%h data=%h count=%0d required 100/7/1", trace_addr, trace_data, trace_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < TMO + 10 && cycle_count != 32'(TMO - 1); i++) tick(1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (cycle_count !== 32'(TMO - 1) || done !== 1'b0) begin
            failures++;
            $display("FAIL timeout_approach cyc=%0d done=%b required %0d/0", cycle_count, done, TMO - 1);
        end
        tick(1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || cycle_count !== 32'(TMO)) begin
            failures++;
            $display("FAIL timeout_hit done=%b pass=%b cyc=%0d required 1/0/%0d", done, pass, cycle_count, TMO);
        end
        for (int i = 0; i < 3; i++) tick(1'b1, 32'h20, 32'h1, 1'b0);
        checks++;
        if (cycle_count !== 32'(TMO) || done !== 1'b1 || trace_count !== 3'd0) begin
            failures++;
            $display("FAIL timeout_hold cyc=%0d done=%b count=%0d required %0d/1/0", cycle_count, done, trace_count, TMO);
        end
        do_reset();
        for (int i = 0; i < TMO + 10 && cycle_count != 32'(TMO - 1); i++) tick(1'b0, 32'h0, 32'h0, 1'b0);
        tick(1'b1, TOHOST, 32'd1, 1'b0);
        checks++;
        if (pass !== 1'b1 || done !== 1'b1 || cycle_count !== 32'(TMO)) begin
            failures++;
            $display("FAIL tohost_priority pass=%b done=%b cyc=%0d required 1/1/%0d", pass, done, cycle_count, TMO);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        tick(1'b1, 32'h40, 32'h4, 1'b1);
        checks++;
        if (trace_count !== 3'd1 || trace_addr !== 32'h40 || trace_data !== 32'h4) begin
            failures++;
            $display("FAIL empty_push_pop count=%0d addr=%h data=%h required 1/40/4", trace_count, trace_addr, trace_data);
        end
        do_reset();
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 32'h50 + 32'(4 * i), 32'(i), 1'b0);
        checks++;
        if (trace_count !== 3'd4 || trace_ovf !== 1'b0) begin
            failures++;
            $display("FAIL fill count=%0d ovf=%b required 4/0", trace_count, trace_ovf);
        end
        tick(1'b1, 32'h60, 32'h99, 1'b0);
        checks++;
        if (trace_count !== 3'd4 || trace_ovf !== 1'b1 || trace_addr !== 32'h50 || trace_data !== 32'h0) begin
            failures++;
            $display("FAIL overflow count=%0d ovf=%b addr=%h data=%h required 4/1/50/0", trace_count, trace_ovf, trace_addr, trace_data);
        end
        tick(1'b1, 32'h64, 32'h77, 1'b1);
        checks++;
        if (trace_count !== 3'd4 || trace_ovf !== 1'b1 || trace_addr !== 32'h54 || trace_data !== 32'h1) begin
            failures++;
            $display("FAIL full_push_pop count=%0d ovf=%b addr=%h data=%h required 4/1/54/1", trace_count, trace_ovf, trace_addr, trace_data);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        tick(1'b1, 32'h70, 32'h1, 1'b0);
        tick(1'b1, TOHOST, 32'd7, 1'b0);
        checks++;
        if (trace_count !== 3'd2 || done !== 1'b1 || fail_code !== 32'd3) begin
            failures++;
            $display("FAIL midrst_setup count=%0d done=%b fail_code=%h required 2/1/3", trace_count, done, fail_code);
        end
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (trace_count !== 3'd0 || done !== 1'b0 || fail_code !== 32'd0 || trace_ovf !== 1'b0 || trace_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_clear count=%0d done=%b fail_code=%h ovf=%b valid=%b required all 0", trace_count, done, fail_code, trace_ovf, trace_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1'b1, 32'h74, 32'h2, 1'b0);
        checks++;
        if (done !== 1'b0 || trace_count !== 3'd1 || trace_addr !== 32'h74 || cycle_count !== 32'd1) begin
            failures++;
            $display("FAIL midrst_run done=%b count=%0d addr=%h cyc=%0d required 0/1/74/1", done, trace_count, trace_addr, cycle_count);
        end
    endtask

    task automatic test_random();
        logic        we, rd;
        logic [31:0] a, d;
        logic [63:0] head;
        int          len;
        for (int seg = 0; seg < 12; seg++) begin
            do_reset();
            len = $urandom_range(20, 70);
            for (int c = 0; c < len; c++) begin
                we = 1'($urandom_range(0, 1));
                rd = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 15) == 0) begin
                    a = TOHOST;
                    d = 32'($urandom_range(0, 3));
                end else begin
                    a = 32'($urandom_range(0, 63)) << 2;
                    d = $urandom;
                end
                tick(we, a, d, rd);
                head = (m_q.size() > 0) ? m_q[0] : 64'd0;
                checks++;
                if ({trace_valid, trace_count, trace_addr, trace_data, trace_ovf, done, pass, fail_code, cycle_count} !==
                    {m_q.size() != 0, 3'(m_q.size()), head, m_ovf, m_state != 0, m_state == 1, m_fail, m_cyc}) begin
                    failures++;
                    $display("FAIL random seg=%0d cyc=%0d got v=%b n=%0d a=%h d=%h o=%b dn=%b p=%b fc=%h cc=%0d required v=%b n=%0d a=%h d=%h o=%b dn=%b p=%b fc=%h cc=%0d",
                             seg, c, trace_valid, trace_count, trace_addr, trace_data, trace_ovf, done, pass, fail_code, cycle_count,
                             m_q.size() != 0, m_q.size(), head[63:32], head[31:0], m_ovf, m_state != 0, m_state == 1, m_fail, m_cyc);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_capture_and_drain();
        test_pass();
        test_fail();
        test_timeout();
        test_overflow();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL bench_timeout simulation time limit reached checks=%0d", checks);
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire
